// File: rtl/alu_op_issuer.sv
// Command-side initiator for the 8-bit registered ALU.
// Queues operation requests, issues one at a time to the ALU, waits out its
// register latency, and returns an in-order tagged response. Commands the ALU
// cannot execute cleanly (unknown opcode, divide by zero) are answered with an
// error response and never reach the ALU.
module alu_op_issuer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_A,
    input  logic [7:0]  cmd_B,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_cin,
    input  logic [3:0]  cmd_tag,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic [3:0]  alu_op_code,
    output logic        alu_C_in,
    input  logic [15:0] alu_Result,
    input  logic        alu_C_out,
    input  logic        alu_Z_flag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_Result,
    output logic        rsp_C_out,
    output logic        rsp_Z_flag,
    output logic [3:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    // Wait counter must hold ALU_LAT; keep at least one bit for ALU_LAT = 0.
    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [AW:0] COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       cin;
        logic [3:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    cmd_t            fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    state_t          state_q;
    logic [CW-1:0]   wait_cnt_q;
    logic [3:0]      op_q;
    logic [3:0]      tag_q;

    cmd_t            cmd_in;
    cmd_t            head;
    logic            push;
    logic            pop;
    logic            head_illegal;

    assign cmd_in    = '{a: cmd_A, b: cmd_B, op: cmd_op, cin: cmd_cin, tag: cmd_tag};
    assign head      = fifo_mem[rd_ptr_q];
    // Ready is forced low while reset is held so nothing is lost mid-flush.
    assign cmd_ready = (count_q != COUNT_FULL) && !Reset;
    assign push      = cmd_valid && cmd_ready;
    // Pop only from IDLE; a freshly pushed entry is visible one edge later.
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head_illegal = (head.op >= 4'd6) || ((head.op == 4'd3) && (head.b == 8'd0));
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    // Command storage; no reset needed since pointers define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy; reset flushes the queue.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Issue FSM: screen and issue the head command, wait out the ALU, hold the response.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_op_code <= '0;
            alu_C_in    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_Result  <= '0;
            rsp_C_out   <= 1'b0;
            rsp_Z_flag  <= 1'b1;
            rsp_tag     <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        if (head_illegal) begin
                            // Rejected: ALU operands are left untouched.
                            rsp_Result <= '0;
                            rsp_C_out  <= 1'b0;
                            rsp_Z_flag <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_tag    <= head.tag;
                            rsp_valid  <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            alu_A       <= head.a;
                            alu_B       <= head.b;
                            alu_op_code <= head.op;
                            alu_C_in    <= head.cin;
                            op_q        <= head.op;
                            tag_q       <= head.tag;
                            wait_cnt_q  <= CW'(ALU_LAT);
                            state_q     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        rsp_Result <= alu_Result;
                        rsp_Z_flag <= alu_Z_flag;
                        // Only add produces a meaningful carry; the ALU's C_out is stale otherwise.
                        rsp_C_out  <= (op_q == 4'd0) ? alu_C_out : 1'b0;
                        rsp_err    <= 1'b0;
                        rsp_tag    <= tag_q;
                        rsp_valid  <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: behavioural ALU environment, a
// queue-based response model checked every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_alu_op_issuer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_A;
    logic [7:0]  cmd_B;
    logic [3:0]  cmd_op;
    logic        cmd_cin;
    logic [3:0]  cmd_tag;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [3:0]  alu_op_code;
    logic        alu_C_in;
    logic [15:0] alu_Result;
    logic        alu_C_out;
    logic        alu_Z_flag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_Result;
    logic        rsp_C_out;
    logic        rsp_Z_flag;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    always #5 CLK = ~CLK;

    alu_op_issuer #(.DEPTH(4), .ALU_LAT(1)) dut (
        .CLK(CLK), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_tag(cmd_tag),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op_code(alu_op_code), .alu_C_in(alu_C_in),
        .alu_Result(alu_Result), .alu_C_out(alu_C_out), .alu_Z_flag(alu_Z_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_Result(rsp_Result), .rsp_C_out(rsp_C_out), .rsp_Z_flag(rsp_Z_flag),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ALU arithmetic: returns {carry, 16-bit result}.
    function automatic logic [16:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] op, input logic cin);
        logic [15:0] r;
        case (op)
            4'd0: r = {8'h00, a} + {8'h00, b} + {15'd0, cin};
            4'd1: r = {8'h00, a} - {8'h00, b};
            4'd2: r = {8'h00, a} * {8'h00, b};
            4'd3: r = (b != 8'd0) ? {8'h00, a / b} : 16'd0;
            4'd4: r = {8'h00, a & b};
            4'd5: r = {8'h00, a ^ b};
            default: r = 16'd0;
        endcase
        return {r[8], r};
    endfunction

    // Registered ALU (one stage); carry only updates on add, so it goes stale otherwise.
    logic [16:0] alu_now;
    assign alu_now = alu_calc(alu_A, alu_B, alu_op_code, alu_C_in);
    initial begin
        alu_Result = 16'd0;
        alu_C_out  = 1'b0;
        alu_Z_flag = 1'b1;
    end
    always @(posedge CLK) begin
        alu_Result <= alu_now[15:0];
        alu_Z_flag <= (alu_now[15:0] == 16'd0);
        if (alu_op_code == 4'd0) alu_C_out <= alu_now[16];
    end

    // Expected response for a command, straight from the command rules.
    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic [3:0]  tag;
        logic        err;
    } rsp_t;

    function automatic rsp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] op, input logic cin, input logic [3:0] tag);
        rsp_t e;
        logic [16:0] v;
        e.tag = tag;
        if (op >= 4'd6 || (op == 4'd3 && b == 8'd0)) begin
            e.res = 16'd0; e.c = 1'b0; e.z = 1'b1; e.err = 1'b1;
        end else begin
            v = alu_calc(a, b, op, cin);
            e.res = v[15:0];
            e.c   = (op == 4'd0) ? v[16] : 1'b0;
            e.z   = (v[15:0] == 16'd0);
            e.err = 1'b0;
        end
        return e;
    endfunction

    rsp_t       exp_q[$];
    logic [3:0] seen_tags[$];
    int         cyc      = 0;
    int         last_acc = 0;
    int         acc_cnt  = 0;
    int         rsp_pops = 0;

    // Accept monitor: every accepted command enqueues its expected response.
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            exp_q.delete();
        end else begin
            cyc++;
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(model(cmd_A, cmd_B, cmd_op, cmd_cin, cmd_tag));
                last_acc = cyc;
                acc_cnt++;
            end
        end
    end

    // Compare process: any presented response must match the model's oldest entry.
    always @(negedge CLK) begin
        if (!Reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("m_result", 32'(rsp_Result), 32'(exp_q[0].res));
                chk("m_cout",   32'(rsp_C_out),  32'(exp_q[0].c));
                chk("m_zflag",  32'(rsp_Z_flag), 32'(exp_q[0].z));
                chk("m_tag",    32'(rsp_tag),    32'(exp_q[0].tag));
                chk("m_err",    32'(rsp_err),    32'(exp_q[0].err));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    seen_tags.push_back(rsp_tag);
                    rsp_pops++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic cin, input logic [3:0] tag);
        int a0;
        a0 = acc_cnt;
        cmd_A = a; cmd_B = b; cmd_op = op; cmd_cin = cin; cmd_tag = tag;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (acc_cnt != a0) break;
        end
        cmd_valid = 1'b0;
        if (acc_cnt == a0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid) begin
                lat = cyc - last_acc;
                break;
            end
        end
        if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_rsp(input string name, input logic [15:0] res, input logic c,
                           input logic z, input logic [3:0] tag, input logic err);
        $display("[TB] %s: result=%04h c=%0d z=%0d tag=%0d err=%0d", name, rsp_Result,
                 rsp_C_out, rsp_Z_flag, rsp_tag, rsp_err);
        chk({name, "_result"}, 32'(rsp_Result), 32'(res));
        chk({name, "_cout"},   32'(rsp_C_out),  32'(c));
        chk({name, "_zflag"},  32'(rsp_Z_flag), 32'(z));
        chk({name, "_tag"},    32'(rsp_tag),    32'(tag));
        chk({name, "_err"},    32'(rsp_err),    32'(err));
    endtask

    int lat;
    int a0;
    int p0;
    int n;

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_A = 8'd0; cmd_B = 8'd0; cmd_op = 4'd0; cmd_cin = 1'b0; cmd_tag = 4'd0;
        #1;
        chk("rst_alu_A", 32'(alu_A), 32'h0);
        chk("rst_alu_op", 32'(alu_op_code), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_z", 32'(rsp_Z_flag), 32'h1);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step(); step();
        Reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // Add with carry.
        send(8'hFF, 8'h01, 4'd0, 1'b1, 4'd3);
        wait_rsp(lat);
        chk("add_latency", 32'(lat), 32'd3);
        chk_rsp("add", 16'h0101, 1'b1, 1'b0, 4'd3, 1'b0);

        // Multiply, then subtract to zero with a stale ALU carry of 1.
        send(8'hFF, 8'hFF, 4'd2, 1'b0, 4'd1);
        wait_rsp(lat);
        chk_rsp("mul", 16'hFE01, 1'b0, 1'b0, 4'd1, 1'b0);
        send(8'h05, 8'h05, 4'd1, 1'b0, 4'd2);
        wait_rsp(lat);
        chk_rsp("sub", 16'h0000, 1'b0, 1'b1, 4'd2, 1'b0);

        // Rejections: divide by zero and an undefined opcode.
        send(8'h05, 8'h00, 4'd3, 1'b0, 4'd7);
        wait_rsp(lat);
        chk("div0_latency", 32'(lat), 32'd1);
        chk_rsp("div0", 16'h0000, 1'b0, 1'b1, 4'd7, 1'b1);
        chk("div0_alu_op_held", 32'(alu_op_code), 32'd1);
        send(8'h12, 8'h34, 4'd9, 1'b0, 4'd8);
        wait_rsp(lat);
        chk("op9_latency", 32'(lat), 32'd1);
        chk_rsp("op9", 16'h0000, 1'b0, 1'b1, 4'd8, 1'b1);
        chk("op9_alu_op_held", 32'(alu_op_code), 32'd1);
        chk("op9_alu_A_held", 32'(alu_A), 32'h05);
        step();

        // Fill with a stalled response: 4 queued + 1 in flight.
        rsp_ready = 1'b0;
        seen_tags.delete();
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            cmd_A = 8'h10 + 8'(i); cmd_B = 8'h20 + 8'(i); cmd_op = 4'd0; cmd_cin = 1'b0;
            cmd_tag = 4'(i); cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        $display("[TB] fill: accepted=%0d cmd_ready=%0d busy=%0d", acc_cnt - a0, cmd_ready, busy);
        chk("fill_accepted", 32'(acc_cnt - a0), 32'd5);
        chk("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);

        // Backpressure: response and operands hold for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_tag", 32'(rsp_tag), 32'd0);
            chk("bp_result", 32'(rsp_Result), 32'h0030);
            chk("bp_alu_A", 32'(alu_A), 32'h10);
            chk("bp_alu_B", 32'(alu_B), 32'h20);
            chk("bp_alu_op", 32'(alu_op_code), 32'h0);
            step();
        end

        // Single-cycle ready pulse pops exactly one response.
        p0 = rsp_pops;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        $display("[TB] pulse: pops=%0d next_tag=%0d", rsp_pops - p0, rsp_tag);
        chk("pulse_pops", 32'(rsp_pops - p0), 32'd1);
        chk("pulse_next_valid", 32'(rsp_valid), 32'd1);
        chk("pulse_next_tag", 32'(rsp_tag), 32'd1);
        chk("pulse_cmd_ready", 32'(cmd_ready), 32'd1);

        // Drain and confirm order.
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        n = seen_tags.size();
        $display("[TB] drain: responses=%0d", n);
        chk("drain_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < n) chk("drain_order", 32'(seen_tags[i]), 32'(i));
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset during WAIT with two commands queued.
        cmd_A = 8'h01; cmd_B = 8'h02; cmd_op = 4'd0; cmd_cin = 1'b0; cmd_tag = 4'd9;
        cmd_valid = 1'b1;
        step();
        cmd_tag = 4'd10;
        step();
        cmd_tag = 4'd11;
        step();
        cmd_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_alu_A", 32'(alu_A), 32'h01);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        Reset = 1'b1;
        #1;
        $display("[TB] mid-wait reset: busy=%0d alu_A=%0h rsp_valid=%0d", busy, alu_A, rsp_valid);
        chk("mr_alu_A", 32'(alu_A), 32'h0);
        chk("mr_alu_B", 32'(alu_B), 32'h0);
        chk("mr_alu_cin", 32'(alu_C_in), 32'h0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mr_rsp_result", 32'(rsp_Result), 32'h0);
        chk("mr_rsp_z", 32'(rsp_Z_flag), 32'h1);
        chk("mr_rsp_tag", 32'(rsp_tag), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'h0);
        step(); step();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("post_mr_idle_valid", 32'(rsp_valid), 32'd0);
        chk("post_mr_idle_busy", 32'(busy), 32'd0);
        send(8'h01, 8'h01, 4'd0, 1'b0, 4'd5);
        wait_rsp(lat);
        chk("post_mr_latency", 32'(lat), 32'd3);
        chk_rsp("post_mr_add", 16'h0002, 1'b0, 1'b0, 4'd5, 1'b0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
